// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Ports: clk, rst_n, a_*/b_* req/gnt requesters, mem_* RAM side.
module ram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] cnt_inc;
  logic          last_b;
  logic          ga;
  logic          gb;
  logic          iss_v;
  logic          iss_b;
  logic          a_rv;
  logic          b_rv;

  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + ONE;

  always_comb begin
    ga       = 1'b0;
    gb       = 1'b0;
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      OWN_A: begin
        if (a_req && (!b_req || cnt < CMAX)) begin
          ga     = 1'b1;
          cnt_nx = cnt_inc;
        end else if (b_req) begin
          gb       = 1'b1;
          state_nx = OWN_B;
          cnt_nx   = ONE;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      OWN_B: begin
        if (b_req && (!a_req || cnt < CMAX)) begin
          gb     = 1'b1;
          cnt_nx = cnt_inc;
        end else if (a_req) begin
          ga       = 1'b1;
          state_nx = OWN_A;
          cnt_nx   = ONE;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        // Tie goes to the port that did not win last.
        if (a_req && (!b_req || last_b)) begin
          ga       = 1'b1;
          state_nx = OWN_A;
          cnt_nx   = ONE;
        end else if (b_req) begin
          gb       = 1'b1;
          state_nx = OWN_B;
          cnt_nx   = ONE;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
    endcase
  end

  assign a_gnt = ga;
  assign b_gnt = gb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_b   <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      iss_v    <= 1'b0;
      iss_b    <= 1'b0;
      a_rv     <= 1'b0;
      b_rv     <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      mem_we <= (ga & a_we) | (gb & b_we);
      if (ga | gb) begin
        last_b <= gb;
      end
      if (ga) begin
        mem_addr <= a_addr;
        mem_din  <= a_din;
      end else if (gb) begin
        mem_addr <= b_addr;
        mem_din  <= b_din;
      end
      // Owner tag follows the access into the RAM read stage.
      iss_v <= ga | gb;
      iss_b <= gb;
      a_rv  <= iss_v & ~iss_b;
      b_rv  <= iss_v & iss_b;
    end
  end

  assign a_rvalid = a_rv;
  assign b_rvalid = b_rv;
  assign a_rdata  = mem_dout;
  assign b_rdata  = mem_dout;

endmodule
